// File: rtl/zombie_round_ctrl_if.sv
// Signal bundle between the round controller and its environment.
//
// Environment -> controller: start (restart pulse), btn (debounced button levels),
//                            rnd / rnd_valid (random hole from the generator).
// Controller -> environment: need_random (random request), mole (one-hot lit hole),
//                            shift (round-end pulse), score, lives, level, game_over.
//
// master: the side driving buttons, start and random values.
// slave:  the round controller.
interface zombie_round_ctrl_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic [2:0]         btn;
    logic [1:0]         rnd;
    logic               rnd_valid;
    logic               need_random;
    logic [2:0]         mole;
    logic               shift;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic [3:0]         level;
    logic               game_over;

    modport master (
        output start, btn, rnd, rnd_valid,
        input  need_random, mole, shift, score, lives, level, game_over
    );

    modport slave (
        input  start, btn, rnd, rnd_valid,
        output need_random, mole, shift, score, lives, level, game_over
    );
endinterface

// File: rtl/zombie_round_ctrl.sv
// Round sequencer for the punch-zombie game.
//
// Requests a random hole, lights exactly one mole LED for a show window, scores hits on
// that hole, charges wrong presses and timeouts against lives, and shortens the show
// window every HITS_PER_LEVEL hits down to TIMEOUT_MIN.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    zombie_round_ctrl_if.slave: start, btn[2:0], rnd[1:0], rnd_valid in;
//          need_random, mole[2:0], shift, score, lives[2:0], level[3:0], game_over out
module zombie_round_ctrl #(
    parameter int unsigned TO_W           = 24,
    parameter int unsigned TIMEOUT_INIT   = 12000000,
    parameter int unsigned TIMEOUT_STEP   = 500000,
    parameter int unsigned TIMEOUT_MIN    = 2000000,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned SCORE_W        = 8
) (
    input logic                clk,
    input logic                rst_n,
    zombie_round_ctrl_if.slave bus
);
    // hit_cnt only ever holds 0..HITS_PER_LEVEL-1
    localparam int unsigned HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [TO_W-1:0] TO_INIT = TO_W'(TIMEOUT_INIT);
    localparam logic [TO_W-1:0] TO_STEP = TO_W'(TIMEOUT_STEP);
    localparam logic [TO_W-1:0] TO_MIN  = TO_W'(TIMEOUT_MIN);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StShow,
        StResolve,
        StOver
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [TO_W-1:0]    reload_q, reload_d;
    logic [2:0]         btn_q;
    logic               hit_q, hit_d;

    logic [2:0] press;
    logic       is_hit;

    // Rising edges only, so a button held across a state change never counts twice.
    assign press  = bus.btn & ~btn_q;
    assign is_hit = |(press & mole_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mole_q    <= '0;
            score_q   <= '0;
            lives_q   <= '0;
            level_q   <= '0;
            hit_cnt_q <= '0;
            timer_q   <= '0;
            reload_q  <= TO_INIT;
            btn_q     <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mole_q    <= mole_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
            timer_q   <= timer_d;
            reload_q  <= reload_d;
            btn_q     <= bus.btn;
            hit_q     <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        score_d   = score_q;
        lives_d   = lives_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        timer_d   = timer_q;
        reload_d  = reload_q;
        hit_d     = hit_q;

        unique case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    score_d   = '0;
                    lives_d   = 3'(LIVES);
                    level_d   = '0;
                    hit_cnt_d = '0;
                    reload_d  = TO_INIT;
                    mole_d    = '0;
                    state_d   = StReq;
                end
            end

            StReq: begin
                // rnd == 3 has no hole; keep asking
                if (bus.rnd_valid && (bus.rnd != 2'd3)) begin
                    mole_d  = 3'b001 << bus.rnd;
                    timer_d = reload_q;
                    state_d = StShow;
                end
            end

            StShow: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TO_W'(1);
                end
                // A hit wins over a wrong press or a timeout in the same cycle.
                if (is_hit) begin
                    hit_d   = 1'b1;
                    mole_d  = '0;
                    state_d = StResolve;
                end else if ((press != 3'b000) || (timer_q <= TO_W'(1))) begin
                    hit_d   = 1'b0;
                    mole_d  = '0;
                    state_d = StResolve;
                end
            end

            StResolve: begin
                if (hit_q) begin
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    if (hit_cnt_q == HC_W'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_d = '0;
                        if (level_q != 4'hF) begin
                            level_d = level_q + 4'd1;
                        end
                        // Floor at TO_MIN without ever wrapping below zero.
                        if ((reload_q >= TO_MIN) && ((reload_q - TO_MIN) >= TO_STEP)) begin
                            reload_d = reload_q - TO_STEP;
                        end else begin
                            reload_d = TO_MIN;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + HC_W'(1);
                    end
                    state_d = StReq;
                end else if (lives_q <= 3'd1) begin
                    lives_d = '0;
                    state_d = StOver;
                end else begin
                    lives_d = lives_q - 3'd1;
                    state_d = StReq;
                end
            end

            default: begin
                state_d = StIdle;
                mole_d  = '0;
            end
        endcase
    end

    assign bus.need_random = (state_q == StReq);
    assign bus.shift       = (state_q == StResolve);
    assign bus.game_over   = (state_q == StOver);
    assign bus.mole        = mole_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
endmodule

// File: tb/tb_zombie_round_ctrl.sv
// Self-checking bench for zombie_round_ctrl: directed game scenarios followed by
// randomized rounds, all checked against a round-level game model.
module tb_zombie_round_ctrl;
    localparam int unsigned TO_W   = 24;
    localparam int unsigned T_INIT = 20;
    localparam int unsigned T_STEP = 4;
    localparam int unsigned T_MIN  = 8;
    localparam int unsigned N_LIVES = 3;
    localparam int unsigned N_HITS  = 2;

    localparam int K_HIT   = 0;
    localparam int K_EXTRA = 1;
    localparam int K_WRONG = 2;
    localparam int K_TOUT  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    zombie_round_ctrl_if #(.SCORE_W(8)) bus ();

    zombie_round_ctrl #(
        .TO_W          (TO_W),
        .TIMEOUT_INIT  (T_INIT),
        .TIMEOUT_STEP  (T_STEP),
        .TIMEOUT_MIN   (T_MIN),
        .LIVES         (N_LIVES),
        .HITS_PER_LEVEL(N_HITS),
        .SCORE_W       (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Game model
    int m_score, m_lives, m_level, m_hits, m_reload;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function void model_start();
        m_score  = 0;
        m_lives  = N_LIVES;
        m_level  = 0;
        m_hits   = 0;
        m_reload = T_INIT;
    endfunction

    function void model_hit();
        if (m_score < 255) m_score++;
        m_hits++;
        if (m_hits == N_HITS) begin
            m_hits = 0;
            if (m_level < 15) m_level++;
            m_reload = (m_reload - int'(T_STEP) < int'(T_MIN)) ? T_MIN : m_reload - T_STEP;
        end
    endfunction

    function void model_miss();
        if (m_lives > 0) m_lives--;
    endfunction

    task automatic check_status(input string where);
        check_eq({where, "_shift"}, bus.shift, 0);
        check_eq({where, "_score"}, bus.score, m_score);
        check_eq({where, "_lives"}, bus.lives, m_lives);
        check_eq({where, "_level"}, bus.level, m_level);
        check_eq({where, "_game_over"}, bus.game_over, (m_lives == 0) ? 1 : 0);
        check_eq({where, "_need_random"}, bus.need_random, (m_lives != 0) ? 1 : 0);
        check_eq({where, "_mole"}, bus.mole, 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model_start();
        check_status("start");
    endtask

    // One round starting in the request state, sampled and driven on falling edges.
    task automatic play_round(input int unsigned hole, input int kind, input int unsigned delay,
                              input int unsigned rejects, input bit held);
        logic [2:0]  mole_exp;
        logic [2:0]  press_val;
        int unsigned lit;
        mole_exp = 3'(1 << hole);
        check_eq("req_need_random", bus.need_random, 1);
        check_eq("req_mole", bus.mole, 0);
        for (int i = 0; i < int'(rejects); i++) begin
            bus.rnd       = 2'd3;
            bus.rnd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("reject_need_random", bus.need_random, 1);
            check_eq("reject_mole", bus.mole, 0);
        end
        if (held) bus.btn = mole_exp;
        bus.rnd       = 2'(hole);
        bus.rnd_valid = 1'b1;
        @(negedge clk);
        bus.rnd_valid = 1'b0;
        bus.rnd       = 2'($urandom);
        check_eq("show_mole", bus.mole, mole_exp);
        check_eq("show_need_random", bus.need_random, 0);
        if (kind == K_TOUT) begin
            lit = 0;
            while (bus.mole == mole_exp && lit < 200) begin
                lit++;
                @(negedge clk);
            end
            check_eq("timeout_lit_cycles", lit, m_reload);
            check_eq("timeout_shift", bus.shift, 1);
            model_miss();
        end else begin
            for (int t = 0; t < int'(delay); t++) begin
                if (held && t == 2) bus.btn = 3'b000;
                @(negedge clk);
                check_eq("lit_mole", bus.mole, mole_exp);
                check_eq("lit_shift", bus.shift, 0);
            end
            case (kind)
                K_HIT:   press_val = mole_exp;
                K_EXTRA: press_val = mole_exp | 3'(1 << ((hole + 1) % 3));
                default: press_val = 3'(1 << ((hole + 1 + $urandom_range(0, 1)) % 3));
            endcase
            bus.btn = press_val;
            @(negedge clk);
            bus.btn = 3'b000;
            check_eq("resolve_shift", bus.shift, 1);
            check_eq("resolve_mole", bus.mole, 0);
            if (kind == K_WRONG) model_miss();
            else model_hit();
        end
        @(negedge clk);
        check_status("after_round");
    endtask

    task automatic check_over_idle();
        for (int i = 0; i < 4; i++) begin
            bus.btn       = 3'($urandom_range(1, 7));
            bus.rnd       = 2'($urandom_range(0, 2));
            bus.rnd_valid = 1'b1;
            @(negedge clk);
            bus.btn = 3'b000;
            check_status("over");
        end
        bus.rnd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned h;
        int          k;
        bus.start     = 1'b0;
        bus.btn       = 3'b000;
        bus.rnd       = 2'd0;
        bus.rnd_valid = 1'b0;
        m_score = 0; m_lives = 0; m_level = 0; m_hits = 0; m_reload = T_INIT;
        repeat (3) @(negedge clk);
        check_eq("rst_mole", bus.mole, 0);
        check_eq("rst_shift", bus.shift, 0);
        check_eq("rst_need_random", bus.need_random, 0);
        check_eq("rst_score", bus.score, 0);
        check_eq("rst_lives", bus.lives, 0);
        check_eq("rst_level", bus.level, 0);
        check_eq("rst_game_over", bus.game_over, 0);
        rst_n = 1'b1;
        // Idle ignores presses and random values
        bus.btn = 3'b111; bus.rnd_valid = 1'b1;
        @(negedge clk);
        bus.btn = 3'b000; bus.rnd_valid = 1'b0;
        check_eq("idle_need_random", bus.need_random, 0);
        check_eq("idle_mole", bus.mole, 0);

        // Game 1: directed rounds
        do_start();
        play_round(1, K_HIT, 2, 0, 1'b0);
        play_round(2, K_TOUT, 0, 0, 1'b0);
        play_round(0, K_EXTRA, 3, 1, 1'b0);
        check_eq("level_after_two_hits", bus.level, 1);
        play_round(0, K_WRONG, 1, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            // Press on the last lit cycle to confirm the window is reload cycles long
            play_round($urandom_range(0, 2), K_HIT, m_reload - 1, $urandom_range(0, 2),
                       (r == 0 || r == 3));
        end
        check_eq("reload_floor_level", bus.level, 4);
        play_round($urandom_range(0, 2), K_TOUT, 0, 0, 1'b0);
        check_eq("game1_over", bus.game_over, 1);
        check_over_idle();

        // Game 2: three misses
        do_start();
        play_round(0, K_WRONG, 0, 0, 1'b0);
        play_round(1, K_TOUT, 0, 0, 1'b0);
        play_round(2, K_WRONG, 5, 0, 1'b0);
        check_eq("game2_over", bus.game_over, 1);
        check_eq("game2_lives", bus.lives, 0);
        check_over_idle();

        // Randomized rounds
        do_start();
        for (int r = 0; r < 30; r++) begin
            if (m_lives == 0) begin
                check_over_idle();
                do_start();
            end
            h = $urandom_range(0, 2);
            k = $urandom_range(0, 9);
            k = (k < 5) ? K_HIT : (k < 6) ? K_EXTRA : (k < 8) ? K_WRONG : K_TOUT;
            play_round(h, k, $urandom_range(0, m_reload - 1), $urandom_range(0, 2), 1'b0);
        end

        // Asynchronous reset in the middle of a show window
        if (m_lives == 0) do_start();
        bus.rnd = 2'd2; bus.rnd_valid = 1'b1;
        @(negedge clk);
        bus.rnd_valid = 1'b0;
        check_eq("pre_reset_mole", bus.mole, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_mole", bus.mole, 0);
        check_eq("async_rst_need_random", bus.need_random, 0);
        check_eq("async_rst_score", bus.score, 0);
        check_eq("async_rst_lives", bus.lives, 0);
        check_eq("async_rst_level", bus.level, 0);
        check_eq("async_rst_game_over", bus.game_over, 0);
        repeat (2) begin
            @(negedge clk);
            check_eq("in_rst_shift", bus.shift, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_need_random", bus.need_random, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/zombie_round_ctrl.md
Name: zombie_round_ctrl

Overview:
- Round sequencer for the punch-zombie game.
- Requests a random hole from the random generator and raises exactly one mole (zombie) LED.
- Watches the three punch buttons, scores hits, charges misses and timeouts against lives, and shortens the show window as the level rises.
- Drives `shift` and `need_random` to the display/random datapath. Sits between the debounced button inputs and the random/display blocks.

Parameters:
- TO_W, 24, timer width.
- TIMEOUT_INIT, 12000000, show-window length in cycles at level 0.
- TIMEOUT_STEP, 500000, window reduction per level-up.
- TIMEOUT_MIN, 2000000, window floor.
- LIVES, 3, lives at game start (1..7).
- HITS_PER_LEVEL, 5, hits needed to advance a level.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start/restart pulse.
- btn  in  3  debounced, synchronized button levels: bit0=btn1, bit1=btn2, bit2=btn3.
- rnd  in  2  random value from the generator.
- rnd_valid  in  1  rnd is valid this cycle.
- need_random  out  1  request for a random value.
- mole  out  3  one-hot lit hole; 0 means none.
- shift  out  1  one-cycle round-end pulse.
- score  out  SCORE_W  hit count.
- lives  out  3  remaining lives.
- level  out  4  current level.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mole, shift, need_random, game_over = 0.
  - score, lives, level, hit_cnt, timer = 0.
  - reload=TIMEOUT_INIT.
  - btn_q=0.
  - Reset mid-round clears everything immediately, with no shift pulse.
- Press detect: btn_q registers btn every cycle; press = btn & ~btn_q. A button held across a state change never counts twice.
- States: IDLE, REQ, SHOW, RESOLVE, OVER.
- IDLE, or OVER, with start=1:
  - score=0, lives=LIVES, level=0, hit_cnt=0, reload=TIMEOUT_INIT.
  - Go to REQ.
  - start is ignored in all other states.
- REQ:
  - need_random=1, level-held.
  - On rnd_valid with rnd in 0..2: mole <= one-hot(rnd), timer <= reload, go to SHOW.
  - On rnd_valid with rnd==3: reject and stay in REQ, need_random stays high.
  - Latency: accept at cycle N, so mole is visible from N+1.
- SHOW:
  - need_random=0. Timer decrements each cycle.
  - Hit if (press & mole)!=0.
  - Wrong-hole miss if press!=0 and not a hit. Hit wins over a wrong press in the same cycle.
  - Timeout miss if timer==1 with no press. The mole is therefore visible exactly reload cycles.
  - On hit or miss, go to RESOLVE next edge with the outcome registered.
- RESOLVE (exactly 1 cycle):
  - mole=0, shift=1.
  - On hit:
    - score+1, saturating at all-ones.
    - hit_cnt+1. When hit_cnt reaches HITS_PER_LEVEL: hit_cnt=0, level+1 (saturating at 15), reload=max(reload-TIMEOUT_STEP, TIMEOUT_MIN). The subtraction must not underflow.
    - Go to REQ.
  - On miss: lives-1. If the result is 0, go to OVER; otherwise go to REQ.
  - New score/lives/level values are visible the cycle after RESOLVE.
- OVER:
  - game_over=1, mole=0. score and level held for display.
  - Presses and rnd_valid are ignored.
- Presses during IDLE, REQ, RESOLVE and OVER are ignored.
- shift is never high for two consecutive cycles.
- need_random is high only in REQ.

Test Plan:
Bench parameters: TIMEOUT_INIT=20, STEP=4, MIN=8, LIVES=3, HITS_PER_LEVEL=2.
- Reset then start; rnd_valid=1, rnd=1 at cycle N: mole=3'b010 at N+1, need_random falls at N+1; press btn[1] at N+3: shift=1 at N+4, score=1 at N+5, lives=3.
- rnd=3 with rnd_valid: mole stays 0 and need_random stays 1; then rnd=0: mole=3'b001.
- Mole 3'b100 with no press: mole stays lit exactly 20 cycles, then one shift pulse and lives 3->2, score unchanged.
- Mole 3'b001, press btn=3'b011 in the same cycle: counted as a hit. Separately, press only btn[2]: miss, lives-1.
- Four hits in a row: level 0->1->2, reload 20->16->12, measured as the mole-lit duration of the next round. Continue hits until reload stays at 8. Button held from REQ into SHOW produces no hit.
- Three misses: game_over=1 and lives=0; presses have no effect; start gives lives=3, score=0, game_over=0. Assert rst_n=0 mid-SHOW: all outputs 0 asynchronously.
